// File: rtl/cei_mochila_pkg.sv
// Platform-level constants for the crossbar arbiters.
// Latency: none (constants only).
// Backpressure: n/a.
package cei_mochila_pkg;

  // Grant budget used for a master whose programmed weight is zero.
  localparam int unsigned XBAR_WRR_DEFAULT_WEIGHT = 1;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by masters, arbiter and downstream crossbar.
// Latency: none (type definitions only).
// Backpressure: carried in-band by req/gnt; responses are not backpressured.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/xbar_rsp_route_fifo.sv
// In-order FIFO of granted master indices used to route read responses back.
// Latency: push visible at head the cycle after the write; pop is combinational on head.
// Backpressure: push ignored when full, pop ignored when empty; owner gates both.
// Ports: clk/rst (sync active-high), push/push_data, pop, head, full, empty, count.
module xbar_rsp_route_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset: contents are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Explicit wrap so non-power-of-two depths stay in range.
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xbar_wrr_arbiter.sv
// Weighted round-robin OBI arbiter: N masters onto one slave port, in-order response routing.
// Latency: request/gnt combinational pass-through; rvalid/rdata routed combinationally.
// Backpressure: a stalled request is locked until gnt; issuing stops at MAX_OUTSTANDING.
// Ports: clk_i/rst_i (sync active-high), weight_i, master_req_i/master_resp_o,
//        slave_req_o/slave_resp_i, outstanding_o (in-flight count), err_o (sticky orphan rvalid).
module xbar_wrr_arbiter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int NMASTER         = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WEIGHT_W        = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NMASTER-1:0][WEIGHT_W-1:0]     weight_i,
  input  obi_req_t  [NMASTER-1:0]              master_req_i,
  output obi_resp_t [NMASTER-1:0]              master_resp_o,
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int IDX_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;

  logic [IDX_W-1:0]    ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic                lock_q;
  logic [IDX_W-1:0]    lock_idx_q;
  logic                err_q;

  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    cand_idx;
  logic                found;
  int                  cand;
  logic                any_req;
  logic                hs;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [IDX_W-1:0]    head;
  logic [WEIGHT_W-1:0] reload;

  always_comb begin
    any_req = 1'b0;
    for (int i = 0; i < NMASTER; i++) any_req |= master_req_i[i].req;
  end

  // Owner keeps the port while it has credit; otherwise scan starts after the owner
  // and wraps back to it. A stalled request freezes the choice until accepted.
  always_comb begin
    sel      = ptr_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (lock_q) begin
      sel = lock_idx_q;
    end else if (credit_q != '0 && master_req_i[ptr_q].req) begin
      sel = ptr_q;
    end else begin
      for (int k = 1; k <= NMASTER; k++) begin
        cand = int'(ptr_q) + k;
        if (cand >= NMASTER) cand -= NMASTER;
        cand_idx = IDX_W'(cand);
        if (!found && master_req_i[cand_idx].req) begin
          sel   = cand_idx;
          found = 1'b1;
        end
      end
    end
  end

  assign reload = ((weight_i[sel] == '0) ? WEIGHT_W'(XBAR_WRR_DEFAULT_WEIGHT) : weight_i[sel])
                  - WEIGHT_W'(1);

  always_comb begin
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = any_req & ~fifo_full & ~rst_i;
  end

  assign hs  = slave_req_o.req & slave_resp_i.gnt;
  assign pop = slave_resp_i.rvalid & ~fifo_empty & ~rst_i;

  always_comb begin
    master_resp_o = '0;
    if (hs) master_resp_o[sel].gnt = 1'b1;
    if (pop) begin
      master_resp_o[head].rvalid = 1'b1;
      master_resp_o[head].rdata  = slave_resp_i.rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      credit_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        lock_q <= 1'b0;
        if (sel == ptr_q && credit_q != '0) begin
          credit_q <= credit_q - WEIGHT_W'(1);
        end else begin
          ptr_q    <= sel;
          credit_q <= reload;
        end
      end else if (slave_req_o.req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (slave_resp_i.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  xbar_rsp_route_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (IDX_W)
  ) u_route_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (hs),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_o)
  );

endmodule

// File: tb/tb_xbar_wrr_arbiter.sv
// Directed bench for the weighted round-robin OBI arbiter.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_xbar_wrr_arbiter;
  import obi_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0][3:0]      weight;
  obi_req_t  [2:0]      mreq;
  obi_resp_t [2:0]      mresp;
  obi_req_t             sreq;
  obi_resp_t            sresp;
  logic [2:0]           outst;
  logic                 err;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  xbar_wrr_arbiter #(
    .NMASTER         (3),
    .MAX_OUTSTANDING (4),
    .WEIGHT_W        (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .weight_i      (weight),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp),
    .outstanding_o (outst),
    .err_o         (err)
  );

  function automatic logic [2:0] gv();
    return {mresp[2].gnt, mresp[1].gnt, mresp[0].gnt};
  endfunction

  function automatic logic [2:0] rv();
    return {mresp[2].rvalid, mresp[1].rvalid, mresp[0].rvalid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    tick();
    rst  = 1'b1;
    mreq = '0;
    sresp = '0;
    tick();
    rst = 1'b0;
  endtask

  int seq31[10] = '{1, 2, 0, 0, 1, 2, 0, 0, 1, 2};
  int seq36[4]  = '{1, 0, 1, 0};

  initial begin
    rst    = 1'b1;
    mreq   = '0;
    sresp  = '0;
    weight = {4'd1, 4'd1, 4'd1};

    // Reset gating: requests, gnt and rvalid all asserted while in reset.
    tick();
    mreq[0].req  = 1'b1;
    sresp.gnt    = 1'b1;
    sresp.rvalid = 1'b1;
    #1;
    chk("rst_slave_req", 32'(sreq.req), 32'd0);
    chk("rst_gnt",       32'(gv()),     32'd0);
    chk("rst_rvalid",    32'(rv()),     32'd0);
    tick();
    #1;
    chk("rst_outstanding", 32'(outst), 32'd0);
    chk("rst_err",         32'(err),   32'd0);

    // Weights {2,1,1}: first pass starts after reset pointer 0, then 0,0,1,2 repeats.
    reset_dut();
    weight = {4'd1, 4'd1, 4'd2};
    for (int i = 0; i < 10; i++) begin
      tick();
      mreq[0].req = 1'b1; mreq[1].req = 1'b1; mreq[2].req = 1'b1;
      sresp.gnt    = 1'b1;
      sresp.rvalid = (i > 0);
      #1;
      chk("wrr_grant", 32'(gv()), 32'(3'b001 << seq31[i]));
      if (i > 0) begin
        chk("wrr_route", 32'(rv()), 32'(3'b001 << seq31[i-1]));
        chk("wrr_outstanding", 32'(outst), 32'd1);
      end
    end
    tick();
    mreq = '0; sresp.gnt = 1'b0; sresp.rvalid = 1'b1;
    #1;
    chk("wrr_drain", 32'(rv()), 32'(3'b001 << seq31[9]));
    tick();
    sresp.rvalid = 1'b0;
    #1;
    chk("wrr_empty", 32'(outst), 32'd0);

    // Lock: master 0 stalled, master 2 joins, request must not move until gnt.
    reset_dut();
    weight = {4'd1, 4'd1, 4'd1};
    tick();
    mreq[0].req = 1'b1; mreq[0].we = 1'b1; mreq[0].addr = 32'h1000_0000; mreq[0].wdata = 32'hDEAD;
    mreq[2].addr = 32'h2000_0000;
    #1;
    chk("lock_req0",  32'(sreq.req), 32'd1);
    chk("lock_addr0", sreq.addr,     32'h1000_0000);
    chk("lock_gnt0",  32'(gv()),     32'd0);
    tick();
    mreq[2].req = 1'b1;
    #1;
    chk("lock_addr1", sreq.addr, 32'h1000_0000);
    tick();
    #1;
    chk("lock_addr2", sreq.addr, 32'h1000_0000);
    chk("lock_we2",   32'(sreq.we), 32'd1);
    tick();
    sresp.gnt = 1'b1;
    #1;
    chk("lock_addr3", sreq.addr, 32'h1000_0000);
    chk("lock_gnt3",  32'(gv()), 32'b001);
    tick();
    mreq[0].req = 1'b0;
    #1;
    chk("lock_next_addr", sreq.addr, 32'h2000_0000);
    chk("lock_next_gnt",  32'(gv()), 32'b100);
    tick();
    mreq = '0; sresp.gnt = 1'b0;
    #1;
    chk("lock_outstanding", 32'(outst), 32'd2);

    // Outstanding limit of 4.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      tick();
      mreq[0].req = 1'b1; mreq[0].addr = 32'h3000_0000; sresp.gnt = 1'b1;
      #1;
      chk("full_fill_gnt", 32'(gv()), 32'b001);
    end
    tick();
    #1;
    chk("full_count", 32'(outst),    32'd4);
    chk("full_req",   32'(sreq.req), 32'd0);
    chk("full_gnt",   32'(gv()),     32'd0);
    tick();
    sresp.rvalid = 1'b1;
    #1;
    chk("full_pop_rvalid", 32'(rv()),     32'b001);
    chk("full_pop_req",    32'(sreq.req), 32'd0);
    tick();
    sresp.rvalid = 1'b0;
    #1;
    chk("full_after_pop_count", 32'(outst),    32'd3);
    chk("full_after_pop_req",   32'(sreq.req), 32'd1);
    chk("full_after_pop_gnt",   32'(gv()),     32'b001);

    // In-order routing: grants to 1, 0, 2 then three responses.
    reset_dut();
    tick();
    mreq[1].req = 1'b1; sresp.gnt = 1'b1;
    #1;
    chk("route_gnt_m1", 32'(gv()), 32'b010);
    tick();
    mreq = '0; mreq[0].req = 1'b1;
    #1;
    chk("route_gnt_m0", 32'(gv()), 32'b001);
    tick();
    mreq = '0; mreq[2].req = 1'b1;
    #1;
    chk("route_gnt_m2", 32'(gv()), 32'b100);
    tick();
    mreq = '0; sresp.gnt = 1'b0; sresp.rvalid = 1'b1; sresp.rdata = 32'hA1;
    #1;
    chk("route_rv_a1",    32'(rv()),      32'b010);
    chk("route_rdata_a1", mresp[1].rdata, 32'hA1);
    tick();
    sresp.rdata = 32'hB2;
    #1;
    chk("route_rv_b2",    32'(rv()),      32'b001);
    chk("route_rdata_b2", mresp[0].rdata, 32'hB2);
    tick();
    sresp.rdata = 32'hC3;
    #1;
    chk("route_rv_c3",    32'(rv()),      32'b100);
    chk("route_rdata_c3", mresp[2].rdata, 32'hC3);
    tick();
    sresp.rvalid = 1'b0;
    #1;
    chk("route_count", 32'(outst), 32'd0);
    chk("route_err",   32'(err),   32'd0);

    // Orphan rvalid: dropped, sticky error, cleared by reset.
    tick();
    sresp.rvalid = 1'b1; sresp.rdata = 32'h55;
    #1;
    chk("orphan_rvalid", 32'(rv()), 32'd0);
    tick();
    sresp.rvalid = 1'b0;
    #1;
    chk("orphan_err",   32'(err),   32'd1);
    chk("orphan_count", 32'(outst), 32'd0);
    tick();
    #1;
    chk("orphan_err_sticky", 32'(err), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("orphan_err_cleared", 32'(err),   32'd0);
    chk("orphan_count_reset", 32'(outst), 32'd0);

    // Weight 0 on master 1 behaves as weight 1.
    reset_dut();
    weight = {4'd1, 4'd0, 4'd1};
    for (int i = 0; i < 4; i++) begin
      tick();
      mreq[0].req = 1'b1; mreq[1].req = 1'b1;
      sresp.gnt    = 1'b1;
      sresp.rvalid = (i > 0);
      #1;
      chk("w0_grant", 32'(gv()), 32'(3'b001 << seq36[i]));
    end
    tick();
    mreq = '0; sresp = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
